// File: rtl/lfsr_decrypt_engine.sv
// LFSR stream decryptor: identifies the keystream tap pattern from a known preamble,
// then re-reads the ciphertext block and writes the decrypted words to memory.
module lfsr_decrypt_engine #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned LFSR_W       = 6,
  parameter int unsigned NUM_TAPS     = 6,
  parameter logic [NUM_TAPS*LFSR_W-1:0] TAPS = {6'h39, 6'h36, 6'h33, 6'h30, 6'h2D, 6'h21},
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned RD_BASE      = 64,
  parameter int unsigned WR_BASE      = 0,
  parameter int unsigned MSG_LEN      = 64,
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter logic [DATA_W-1:0] PRE_SYM = 8'h5F,
  localparam int unsigned SEL_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic                clk,
  input  logic                init,
  input  logic                start,
  output logic [ADDR_W-1:0]   raddr,
  input  logic [DATA_W-1:0]   data_out,
  output logic [ADDR_W-1:0]   waddr,
  output logic [DATA_W-1:0]   data_in,
  output logic                wr_en,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [SEL_W-1:0]    sel_idx,
  output logic [NUM_TAPS-1:0] match_vec
);

  localparam int unsigned CNT_W = $clog2(MSG_LEN + PREAMBLE_LEN + 2);
  localparam logic [LFSR_W-1:0] PRE_KEY = PRE_SYM[LFSR_W-1:0];
  localparam logic [ADDR_W-1:0] RD_START = ADDR_W'(RD_BASE);
  localparam logic [ADDR_W-1:0] WR_START = ADDR_W'(WR_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAIN,
    S_DECIDE,
    S_DECRYPT,
    S_DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [LFSR_W-1:0]   lfsr [NUM_TAPS];
  logic [LFSR_W-1:0]   lfsr_adv_c [NUM_TAPS];
  logic [LFSR_W-1:0]   key;
  logic [LFSR_W-1:0]   sel_taps;
  logic [LFSR_W-1:0]   obs_c;
  logic [LFSR_W-1:0]   ks_c;
  logic [SEL_W-1:0]    first_c;
  logic [LFSR_W-1:0]   first_taps_c;
  logic                any_c;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] t);
    return {s[LFSR_W-2:0], ^(s & t)};
  endfunction

  // Keystream value implied by the incoming word if it were a preamble symbol.
  assign obs_c = data_out[LFSR_W-1:0] ^ PRE_KEY;
  // First decrypted word keys off the seed directly; later words off the running LFSR.
  assign ks_c  = (cnt == CNT_W'(1)) ? obs_c : key;

  always_comb begin
    for (int j = 0; j < NUM_TAPS; j++) begin
      lfsr_adv_c[j] = lfsr_next(lfsr[j], TAPS[j*LFSR_W +: LFSR_W]);
    end
  end

  // Lowest-index surviving pattern wins.
  always_comb begin
    first_c      = '0;
    first_taps_c = TAPS[LFSR_W-1:0];
    any_c        = 1'b0;
    for (int j = NUM_TAPS - 1; j >= 0; j--) begin
      if (match_vec[j]) begin
        first_c      = SEL_W'(j);
        first_taps_c = TAPS[j*LFSR_W +: LFSR_W];
        any_c        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state     <= S_IDLE;
      cnt       <= '0;
      raddr     <= RD_START;
      waddr     <= WR_START;
      data_in   <= '0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      sel_idx   <= '0;
      match_vec <= '0;
      key       <= '0;
      sel_taps  <= '0;
      for (int j = 0; j < NUM_TAPS; j++) begin
        lfsr[j] <= '0;
      end
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_TRAIN;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
          end
        end

        S_TRAIN: begin
          raddr <= raddr + ADDR_W'(1);
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            for (int j = 0; j < NUM_TAPS; j++) begin
              lfsr[j] <= obs_c;
            end
            match_vec <= '1;
          end else if (cnt >= CNT_W'(2)) begin
            for (int j = 0; j < NUM_TAPS; j++) begin
              lfsr[j] <= lfsr_adv_c[j];
              if (lfsr_adv_c[j] != obs_c) begin
                match_vec[j] <= 1'b0;
              end
            end
          end
          if (cnt == CNT_W'(PREAMBLE_LEN)) begin
            state <= S_DECIDE;
          end
        end

        S_DECIDE: begin
          sel_idx  <= first_c;
          sel_taps <= first_taps_c;
          err      <= ~any_c;
          raddr    <= RD_START;
          cnt      <= '0;
          if (any_c) begin
            state <= S_DECRYPT;
          end else begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        S_DECRYPT: begin
          cnt   <= cnt + CNT_W'(1);
          raddr <= (cnt == CNT_W'(MSG_LEN)) ? RD_START : raddr + ADDR_W'(1);
          if (cnt != '0) begin
            wr_en   <= 1'b1;
            waddr   <= WR_START + ADDR_W'(cnt - CNT_W'(1));
            data_in <= data_out ^ DATA_W'(ks_c);
            key     <= lfsr_next(ks_c, sel_taps);
          end
          if (cnt == CNT_W'(MSG_LEN)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Bench for lfsr_decrypt_engine: default instance plus a 7-bit/9-pattern instance with
// a wrapping read window, checked against a word-level cipher model.
module tb_lfsr_decrypt_engine;

  localparam int P = 7;

  logic       clk;
  logic       init;
  logic       start_a, start_b;
  logic [7:0] raddr_a, raddr_b, waddr_a, waddr_b, din_a, din_b, dout_a, dout_b;
  logic       we_a, we_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [2:0] sel_a;
  logic [3:0] sel_b;
  logic [5:0] mv_a;
  logic [8:0] mv_b;

  lfsr_decrypt_engine u_a (
    .clk(clk), .init(init), .start(start_a), .raddr(raddr_a), .data_out(dout_a),
    .waddr(waddr_a), .data_in(din_a), .wr_en(we_a), .busy(busy_a), .done(done_a),
    .err(err_a), .sel_idx(sel_a), .match_vec(mv_a)
  );

  lfsr_decrypt_engine #(
    .LFSR_W(7), .NUM_TAPS(9),
    .TAPS({7'h65, 7'h41, 7'h5C, 7'h4E, 7'h60, 7'h50, 7'h48, 7'h44, 7'h42}),
    .RD_BASE(8'hF0), .WR_BASE(8'h40), .MSG_LEN(32)
  ) u_b (
    .clk(clk), .init(init), .start(start_b), .raddr(raddr_b), .data_out(dout_b),
    .waddr(waddr_b), .data_in(din_b), .wr_en(we_b), .busy(busy_b), .done(done_b),
    .err(err_b), .sel_idx(sel_b), .match_vec(mv_b)
  );

  int         total, bad, cyc;
  bit         run_on [2];
  int         s0 [2], lat [2], wr_idx [2], exp_sel [2], exp_mv [2];
  bit         exp_err [2];
  logic [7:0] exp_pt [2][256];
  logic [7:0] orig_pt [2][256];
  logic [7:0] cmem [2][256];
  logic [7:0] pmem [2][256];
  logic [1:0] clr;
  int         taps_a [6] = '{'h21, 'h2D, 'h30, 'h33, 'h36, 'h39};
  int         taps_b [9] = '{'h42, 'h44, 'h48, 'h50, 'h60, 'h4E, 'h5C, 'h41, 'h65};
  string      msg = "Hello, LFSR world! 0123456789 ";

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory: ciphertext image for reads, separate plaintext image for writes.
  always @(posedge clk) begin
    dout_a <= cmem[0][raddr_a];
    dout_b <= cmem[1][raddr_b];
    for (int i = 0; i < 2; i++) begin
      if (clr[i]) begin
        for (int k = 0; k < 256; k++) pmem[i][k] <= 8'hA5 ^ 8'(k);
      end
    end
    if (!clr[0] && we_a) pmem[0][waddr_a] <= din_a;
    if (!clr[1] && we_b) pmem[1][waddr_b] <= din_b;
  end

  function automatic int mlen(int i);  return i ? 32 : 64;     endfunction
  function automatic int rbase(int i); return i ? 'hF0 : 64;   endfunction
  function automatic int wbase(int i); return i ? 'h40 : 0;    endfunction
  function automatic int lw(int i);    return i ? 7 : 6;       endfunction
  function automatic int ntaps(int i); return i ? 9 : 6;       endfunction
  function automatic int tap(int i, int j); return i ? taps_b[j] : taps_a[j]; endfunction

  function automatic int step(int s, int t, int w);
    return ((s << 1) | ($countones(s & t) & 1)) & ((1 << w) - 1);
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Encrypt a message with pattern j/seed, optionally corrupt one word, then derive expectations.
  task automatic build(int i, int j, int seed, int bad_k);
    int w, m, mask, s, c, p, mv;
    int ctv [256];
    bit ok;
    w = lw(i); m = mlen(i); mask = (1 << w) - 1; s = seed;
    for (int k = 0; k < m; k++) begin
      p = (k < P) ? 'h5F : int'(msg[(k - P) % msg.len()]);
      orig_pt[i][k] = 8'(p);
      c = p ^ s;
      if (k == bad_k) c = c ^ 1;
      ctv[k] = c;
      cmem[i][(rbase(i) + k) % 256] = 8'(c);
      s = step(s, tap(i, j), w);
    end
    mv = 0;
    for (int jj = 0; jj < ntaps(i); jj++) begin
      s = (ctv[0] ^ 'h5F) & mask;
      ok = 1'b1;
      for (int k = 1; k < P; k++) begin
        s = step(s, tap(i, jj), w);
        if (s != ((ctv[k] ^ 'h5F) & mask)) ok = 1'b0;
      end
      if (ok) mv |= (1 << jj);
    end
    exp_mv[i] = mv;
    exp_err[i] = (mv == 0);
    exp_sel[i] = 0;
    for (int jj = ntaps(i) - 1; jj >= 0; jj--) if (mv[jj]) exp_sel[i] = jj;
    s = (ctv[0] ^ 'h5F) & mask;
    for (int k = 0; k < m; k++) begin
      exp_pt[i][k] = 8'(ctv[k] ^ s);
      s = step(s, tap(i, exp_sel[i]), w);
    end
    lat[i] = exp_err[i] ? P + 2 : P + m + 3;
  endtask

  task automatic set_start(int i, logic v);
    if (i != 0) start_b = v; else start_a = v;
  endtask

  function automatic logic get_done(int i);
    return (i != 0) ? done_b : done_a;
  endfunction

  task automatic clear(int i);
    @(negedge clk); clr[i] = 1'b1;
    @(negedge clk); clr[i] = 1'b0;
  endtask

  task automatic begin_run(int i);
    @(negedge clk);
    set_start(i, 1'b1);
    s0[i] = cyc + 1; wr_idx[i] = 0; run_on[i] = 1'b1;
    @(negedge clk);
    set_start(i, 1'b0);
  endtask

  // Run to done; poke pulses start while busy. Returns cycles from start sample to done.
  task automatic run(int i, bit poke, output int dcyc);
    int n;
    clear(i);
    begin_run(i);
    dcyc = -1; n = 0;
    while (dcyc < 0 && n < 300) begin
      if (get_done(i)) dcyc = cyc - s0[i];
      else begin
        set_start(i, poke && (cyc - s0[i] == 5 || cyc - s0[i] == 20));
        @(negedge clk);
        n++;
      end
    end
    set_start(i, 1'b0);
    if (dcyc < 0) chk($sformatf("timeout%0d", i), 1, 0);
    repeat (2) @(negedge clk);
    run_on[i] = 1'b0;
    chk($sformatf("nwrites%0d", i), wr_idx[i], exp_err[i] ? 0 : mlen(i));
  endtask

  task automatic chk_mem(int i, bit clean);
    int nm, a;
    nm = 0;
    for (int k = 0; k < mlen(i); k++) begin
      a = (wbase(i) + k) % 256;
      if (pmem[i][a] != (clean ? (8'hA5 ^ 8'(a)) : orig_pt[i][k])) nm++;
    end
    chk($sformatf("mem%0d", i), nm, 0);
  endtask

  // Per-cycle check of handshake, read addresses and write stream against the model.
  task automatic cmp_inst(int i, logic b, logic d, logic we, logic [7:0] wa, logic [7:0] wd,
                          logic [7:0] ra);
    int rel, dr;
    if (!run_on[i]) return;
    rel = cyc - s0[i];
    if (rel < 0) return;
    chk($sformatf("busy%0d", i), int'(b), int'(rel < lat[i]));
    chk($sformatf("done%0d", i), int'(d), int'(rel >= lat[i]));
    dr = rel - (P + 2);
    if (rel < P) chk($sformatf("raddr_tr%0d", i), int'(ra), (rbase(i) + rel) % 256);
    else if (!exp_err[i] && dr >= 0 && dr < mlen(i))
      chk($sformatf("raddr_dc%0d", i), int'(ra), (rbase(i) + dr) % 256);
    if (we) begin
      if (rel > lat[i] || exp_err[i] || wr_idx[i] >= mlen(i)) begin
        chk($sformatf("stray_wr%0d", i), 1, 0);
      end else begin
        chk($sformatf("waddr%0d", i), int'(wa), (wbase(i) + wr_idx[i]) % 256);
        chk($sformatf("wdata%0d", i), int'(wd), int'(exp_pt[i][wr_idx[i]]));
        wr_idx[i]++;
      end
    end
  endtask

  initial begin
    int d, np;
    total = 0; bad = 0; cyc = 0;
    init = 1'b1; start_a = 1'b0; start_b = 1'b0; clr = 2'b00;
    for (int i = 0; i < 2; i++) begin
      run_on[i] = 1'b0;
      for (int k = 0; k < 256; k++) cmem[i][k] = 8'h00;
    end

    fork
      forever begin
        @(negedge clk);
        cmp_inst(0, busy_a, done_a, we_a, waddr_a, din_a, raddr_a);
        cmp_inst(1, busy_b, done_b, we_b, waddr_b, din_b, raddr_b);
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_raddr", int'(raddr_a), 64);
    chk("rst_waddr", int'(waddr_a), 0);
    chk("rst_wr_en", int'(we_a), 0);
    chk("rst_data_in", int'(din_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_err", int'(err_a), 0);
    chk("rst_sel", int'(sel_a), 0);
    chk("rst_mv", int'(mv_a), 0);
    chk("rst_raddr_b", int'(raddr_b), 'hF0);
    @(negedge clk); init = 1'b0;

    // Pattern 3, seed 1: only pattern 3 survives
    build(0, 3, 'h01, -1);
    run(0, 1'b0, d);
    chk("t1_lat", d, 74);
    chk("t1_mv", int'(mv_a), 'b001000);
    chk("t1_sel", int'(sel_a), 3);
    chk("t1_err", int'(err_a), 0);
    chk("t1_model_mv", exp_mv[0], 'b001000);
    chk_mem(0, 1'b0);
    np = 0;
    for (int k = 0; k < P; k++) if (pmem[0][k] != 8'h5F) np++;
    chk("t1_preamble", np, 0);

    // Sweep every pattern with seed 2A, restarting from DONE
    for (int j = 0; j < 6; j++) begin
      build(0, j, 'h2A, -1);
      run(0, 1'b0, d);
      chk($sformatf("sw%0d_sel", j), int'(sel_a), j);
      chk($sformatf("sw%0d_mv", j), int'(mv_a), 1 << j);
      chk($sformatf("sw%0d_lat", j), d, 74);
      chk_mem(0, 1'b0);
    end

    // Corrupted preamble word 3: no survivor, no writes
    build(0, 3, 'h01, 3);
    run(0, 1'b0, d);
    chk("err_lat", d, 9);
    chk("err_flag", int'(err_a), 1);
    chk("err_mv", int'(mv_a), 0);
    chk_mem(0, 1'b1);

    // Zero seed: every pattern holds at zero
    build(0, 3, 'h00, -1);
    run(0, 1'b0, d);
    chk("z_mv", int'(mv_a), 'h3F);
    chk("z_sel", int'(sel_a), 0);
    chk("z_err", int'(err_a), 0);
    chk_mem(0, 1'b0);

    // Reset in the middle of the decrypt pass, then a clean rerun
    build(0, 3, 'h01, -1);
    clear(0);
    begin_run(0);
    while (cyc - s0[0] < 30) @(negedge clk);
    chk("abort_we_before", int'(we_a), 1);
    run_on[0] = 1'b0;
    init = 1'b1;
    #1;
    chk("abort_we", int'(we_a), 0);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_done", int'(done_a), 0);
    chk("abort_raddr", int'(raddr_a), 64);
    chk("abort_waddr", int'(waddr_a), 0);
    chk("abort_mv", int'(mv_a), 0);
    @(negedge clk); init = 1'b0;
    run(0, 1'b0, d);
    chk("rerun_lat", d, 74);
    chk("rerun_sel", int'(sel_a), 3);
    chk_mem(0, 1'b0);

    // 7-bit, 9-pattern instance with wrapping read window and starts while busy
    build(1, 7, 'h01, -1);
    run(1, 1'b1, d);
    chk("b_lat", d, 42);
    chk("b_sel", int'(sel_b), 7);
    chk("b_mv", int'(mv_b), 'h080);
    chk("b_err", int'(err_b), 0);
    chk_mem(1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_decrypt_engine.md
Name: lfsr_decrypt_engine

Overview:
Parametrised LFSR stream decryptor. It reads a ciphertext block from data memory and identifies which of NUM_TAPS candidate tap patterns produced the keystream, using a known preamble. It then decrypts the whole block into a second memory region. It replaces hard-coded six-LFSR, fixed-cycle top levels and sits between the lab controller and a 1-read/1-write dat_mem.

Parameters:
DATA_W, 8, memory word width
LFSR_W, 6, LFSR width (LFSR_W <= DATA_W)
NUM_TAPS, 6, number of candidate tap patterns
TAPS, {6'h39,6'h36,6'h33,6'h30,6'h2D,6'h21}, packed NUM_TAPS*LFSR_W; pattern j in bits [j*LFSR_W +: LFSR_W]
ADDR_W, 8, memory address width
RD_BASE, 64, first ciphertext address
WR_BASE, 0, first plaintext address
MSG_LEN, 64, words decrypted (preamble included)
PREAMBLE_LEN, 7, leading words known to be PRE_SYM (2 <= PREAMBLE_LEN <= MSG_LEN)
PRE_SYM, 8'h5F, preamble plaintext symbol

Ports:
clk  in  1  clock, all state on rising edge
init  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to begin; sampled in IDLE or DONE only
raddr  out  ADDR_W  memory read address
data_out  in  DATA_W  memory read data, valid one cycle after raddr
waddr  out  ADDR_W  memory write address
data_in  out  DATA_W  memory write data
wr_en  out  1  memory write strobe
busy  out  1  high in TRAIN/DECIDE/DECRYPT
done  out  1  high in DONE
err  out  1  no candidate matched preamble; valid with done
sel_idx  out  $clog2(NUM_TAPS)  chosen pattern index; valid with done
match_vec  out  NUM_TAPS  per-pattern survivor flags after training

Behaviour:
- Cipher model: ct[k] = pt[k] ^ {0, s_k}; s_0 = seed; s_{k+1} = {s_k[LFSR_W-2:0], ^(s_k & taps)}. Only low LFSR_W bits are keyed; upper bits pass through.
- Reset (init=1, async): state IDLE; raddr=RD_BASE, waddr=WR_BASE, wr_en=0, data_in=0, busy=0, done=0, err=0, sel_idx=0, match_vec=0. Reset mid-operation aborts with no further writes; wr_en drops asynchronously.
- IDLE: raddr=RD_BASE. start=1 -> TRAIN, word index k=0.
- TRAIN: PREAMBLE_LEN+1 cycles.
  - Cycle c (0..PREAMBLE_LEN-1) issues raddr=RD_BASE+c.
  - Cycle c=1 receives ct[0]: all NUM_TAPS LFSRs load seed = ct[0][LFSR_W-1:0]^PRE_SYM[LFSR_W-1:0]; match_vec set all-ones.
  - Each later cycle receiving ct[k], k>=1: every LFSR advances once; match_vec[j] &= (state_j == ct[k][LFSR_W-1:0]^PRE_SYM[LFSR_W-1:0]).
- DECIDE: 1 cycle. sel_idx = lowest j with match_vec[j]=1 (priority LSB first); err = ~|match_vec. If err -> DONE with no writes. Otherwise -> DECRYPT.
- DECRYPT: MSG_LEN+1 cycles; single re-read pass of RD_BASE..RD_BASE+MSG_LEN-1.
  - The selected LFSR reseeds from ct[0] exactly as in TRAIN.
  - Cycle d (1..MSG_LEN) receives ct[d-1] and drives wr_en=1, waddr=WR_BASE+d-1, data_in=ct[d-1]^{0,s_{d-1}}. The LFSR advances after each write.
  - wr_en=0 in cycle 0.
- DONE: done=1, busy=0; done, err, sel_idx and match_vec hold until start (restart -> TRAIN, done clears next cycle) or init.
- Latency: start sampled at edge E0; done first high PREAMBLE_LEN+MSG_LEN+3 cycles later (74 with defaults), or PREAMBLE_LEN+2 cycles later on err (9).
- Address arithmetic is modulo 2^ADDR_W; wrap is legal and not flagged.
- start while busy is ignored.
- Degenerate seed 0: all patterns stay at 0, so all match and sel_idx=0. This is defined behaviour, not an error.
- Exactly MSG_LEN writes per successful run; never writes outside WR_BASE..WR_BASE+MSG_LEN-1 (mod 2^ADDR_W).

Test Plan:
- Defaults, message "_______Hello..." encrypted with pattern 3 (6'h33), seed 6'h01, start -> match_vec=6'b001000, sel_idx=3, err=0, done at cycle 74, mem[0..63] equals plaintext, mem[0..6]=8'h5F.
- Sweep pattern j=0..5, seed 6'h2A -> sel_idx=j each run; verify keystream against reference model.
- Ciphertext with preamble word 3 corrupted (no pattern fits) -> err=1, done at cycle 9, wr_en never asserted, mem[0..63] unchanged.
- Seed 0 (ct[0][5:0]=6'h1F^... giving zero state) -> match_vec=6'b111111, sel_idx=0, plaintext correct.
- init asserted at cycle 30 mid-DECRYPT -> wr_en low same cycle, outputs at reset values; new start completes a correct full run.
- Parameters LFSR_W=7, NUM_TAPS=9, MSG_LEN=32, RD_BASE=8'hF0 (read wrap) -> correct pattern found, 32 writes, done at cycle PREAMBLE_LEN+35; start during busy ignored.
